// File: rtl/wb_regfile_commit.sv
// Write-back commit stage: architectural register file with two bypassed read ports,
// plus a retired-write counter and a trace of the most recent committed write.
module wb_regfile_commit #(
    parameter int REGWRITE_BIT = 6,
    parameter int CNT_W        = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] d2_WB,
    input  logic [4:0]         rd_WB,
    input  logic [7:0]         control_WB,
    input  logic [4:0]         rs,
    input  logic [4:0]         rt,
    output logic signed [31:0] d_rs,
    output logic signed [31:0] d_rt,
    output logic               wb_commit,
    output logic [4:0]         wb_last_rd,
    output logic [31:0]        wb_last_d,
    output logic [CNT_W-1:0]   retire_cnt
);

    logic        we;
    logic [31:0] regs_reg [32];
    logic [4:0]  rd_addr [2];
    logic [31:0] rd_data [2];

    // Writes to r0 are dropped entirely, so r0 keeps its reset value of zero forever.
    assign we = control_WB[REGWRITE_BIT] && (rd_WB != 5'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we) begin
            regs_reg[rd_WB] <= d2_WB;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_commit  <= 1'b0;
            wb_last_rd <= '0;
            wb_last_d  <= '0;
            retire_cnt <= '0;
        end else begin
            wb_commit <= we;
            if (we) begin
                wb_last_rd <= rd_WB;
                wb_last_d  <= d2_WB;
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    assign rd_addr[0] = rs;
    assign rd_addr[1] = rt;

    // Write-through bypass lets ID see the value being committed in the same cycle;
    // the reset gate keeps the bypass from leaking d2_WB while reset is held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rd_data[gi] = '0;
                if (reset && (rd_addr[gi] != 5'd0)) begin
                    if (we && (rd_addr[gi] == rd_WB)) begin
                        rd_data[gi] = d2_WB;
                    end else begin
                        rd_data[gi] = regs_reg[rd_addr[gi]];
                    end
                end
            end
        end
    endgenerate

    assign d_rs = rd_data[0];
    assign d_rt = rd_data[1];

endmodule

// File: tb/tb_wb_regfile_commit.sv
// Directed bench for wb_regfile_commit: reset, commit, bypass, r0 guard, disabled write,
// back-to-back commits and retire counter wrap (counter narrowed to 4 bits).
module tb_wb_regfile_commit;

    logic               clock;
    logic               reset;
    logic signed [31:0] d2_WB;
    logic [4:0]         rd_WB;
    logic [7:0]         control_WB;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic signed [31:0] d_rs;
    logic signed [31:0] d_rt;
    logic               wb_commit;
    logic [4:0]         wb_last_rd;
    logic [31:0]        wb_last_d;
    logic [3:0]         retire_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    wb_regfile_commit #(.REGWRITE_BIT(6), .CNT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .d2_WB      (d2_WB),
        .rd_WB      (rd_WB),
        .control_WB (control_WB),
        .rs         (rs),
        .rt         (rt),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .wb_commit  (wb_commit),
        .wb_last_rd (wb_last_rd),
        .wb_last_d  (wb_last_d),
        .retire_cnt (retire_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset      = 1'b0;
        d2_WB      = '0;
        rd_WB      = '0;
        control_WB = '0;
        rs         = '0;
        rt         = '0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_retire", 32'(retire_cnt), 32'd0);
        check("rst_commit", 32'(wb_commit), 32'd0);
        check("rst_last_rd", 32'(wb_last_rd), 32'd0);
        check("rst_last_d", wb_last_d, 32'd0);

        @(negedge clock);
        reset = 1'b1;

        // Commit r5 = DEADBEEF; bypass visible in the same cycle
        @(negedge clock);
        control_WB = 8'h40; rd_WB = 5'd5; d2_WB = 32'hDEADBEEF; rs = 5'd5; rt = 5'd0;
        #1;
        check("r5_bypass", d_rs, 32'hDEADBEEF);
        check("rt0_zero", d_rt, 32'd0);
        @(negedge clock);
        control_WB = 8'h00;
        #1;
        check("r5_stored", d_rs, 32'hDEADBEEF);
        check("r5_commit", 32'(wb_commit), 32'd1);
        check("r5_last_rd", 32'(wb_last_rd), 32'd5);
        check("r5_last_d", wb_last_d, 32'hDEADBEEF);
        check("r5_retire", 32'(retire_cnt), 32'd1);

        // r9 = 100, then same-cycle bypass of -7 hides the old value on both ports
        @(negedge clock);
        control_WB = 8'hC0; rd_WB = 5'd9; d2_WB = 32'd100;
        @(negedge clock);
        control_WB = 8'h40; d2_WB = -32'sd7; rs = 5'd9; rt = 5'd9;
        #1;
        check("byp_rs", d_rs, 32'hFFFFFFF9);
        check("byp_rt", d_rt, 32'hFFFFFFF9);
        @(negedge clock);
        control_WB = 8'h00;
        #1;
        check("r9_stored", d_rt, 32'hFFFFFFF9);
        check("r9_retire", 32'(retire_cnt), 32'd3);

        // Write to r0 is dropped
        @(negedge clock);
        control_WB = 8'h40; rd_WB = 5'd0; d2_WB = 32'd123; rs = 5'd0; rt = 5'd0;
        #1;
        check("r0_read", d_rs, 32'd0);
        @(negedge clock);
        control_WB = 8'h00;
        #1;
        check("r0_commit", 32'(wb_commit), 32'd0);
        check("r0_retire", 32'(retire_cnt), 32'd3);
        check("r0_last_rd", 32'(wb_last_rd), 32'd9);
        check("r0_after", d_rs, 32'd0);

        // Write-enable bit clear (load bit only)
        @(negedge clock);
        control_WB = 8'h80; rd_WB = 5'd3; d2_WB = 32'd55; rs = 5'd3;
        #1;
        check("dis_nobyp", d_rs, 32'd0);
        @(negedge clock);
        control_WB = 8'h00;
        #1;
        check("dis_r3", d_rs, 32'd0);
        check("dis_commit", 32'(wb_commit), 32'd0);
        check("dis_retire", 32'(retire_cnt), 32'd3);

        // Back-to-back commits: r31 (JAL) then r1 (ALU)
        @(negedge clock);
        control_WB = 8'h40; rd_WB = 5'd31; d2_WB = 32'h11112222;
        @(negedge clock);
        rd_WB = 5'd1; d2_WB = 32'h33334444;
        @(negedge clock);
        control_WB = 8'h00; rs = 5'd31; rt = 5'd1;
        #1;
        check("b2b_r31", d_rs, 32'h11112222);
        check("b2b_r1", d_rt, 32'h33334444);
        check("b2b_retire", 32'(retire_cnt), 32'd5);
        check("b2b_last_rd", 32'(wb_last_rd), 32'd1);
        check("b2b_commit", 32'(wb_commit), 32'd1);

        // Ten more commits reach 15, one more wraps to 0
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            control_WB = 8'h40; rd_WB = 5'(10 + i); d2_WB = i;
        end
        @(negedge clock);
        control_WB = 8'h00; rs = 5'd19;
        #1;
        check("cnt_15", 32'(retire_cnt), 32'd15);
        check("r19_val", d_rs, 32'd9);
        @(negedge clock);
        control_WB = 8'h40; rd_WB = 5'd2; d2_WB = 32'd77;
        @(negedge clock);
        control_WB = 8'h00;
        #1;
        check("cnt_wrap", 32'(retire_cnt), 32'd0);
        check("wrap_commit", 32'(wb_commit), 32'd1);

        // Asynchronous reset mid-cycle with a pending write
        @(negedge clock);
        control_WB = 8'h40; rd_WB = 5'd7; d2_WB = 32'd77; rs = 5'd7; rt = 5'd31;
        #1;
        check("pre_rst_byp", d_rs, 32'd77);
        #1;
        reset = 1'b0;
        #1;
        check("arst_rs", d_rs, 32'd0);
        check("arst_rt", d_rt, 32'd0);
        check("arst_retire", 32'(retire_cnt), 32'd0);
        check("arst_commit", 32'(wb_commit), 32'd0);
        check("arst_last_d", wb_last_d, 32'd0);
        @(negedge clock);
        control_WB = 8'h00;
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("post_rst_r7", d_rs, 32'd0);
        check("post_rst_retire", 32'(retire_cnt), 32'd0);
        @(negedge clock);
        control_WB = 8'h40; rd_WB = 5'd7; d2_WB = 32'd88;
        @(negedge clock);
        control_WB = 8'h00;
        #1;
        check("post_rst_write", d_rs, 32'd88);
        check("post_rst_cnt1", 32'(retire_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
